// File: rtl/fdiv_period_meter.sv
// fdiv_period_meter: measures clk cycles spanned by N_PER rising edges of a divided input clock
module fdiv_period_meter #(
  parameter int CNT_W = 16,
  parameter int N_PER = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in,
  output logic [CNT_W-1:0] period,
  output logic             valid,
  output logic             ovf,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;
  state_t state;
  logic s1, s2, hist;
  logic [CNT_W-1:0] cnt;
  logic [7:0] per_cnt;
  logic rise, sat, term;
  assign rise = s2 & ~hist;
  assign sat  = cnt == {CNT_W{1'b1}};
  assign term = state == MEASURE && rise && per_cnt == 8'(N_PER - 1);
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      s1      <= 1'b0;
      s2      <= 1'b0;
      hist    <= 1'b0;
      cnt     <= '0;
      per_cnt <= '0;
      period  <= '0;
      valid   <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      s1    <= in;
      s2    <= s1;
      hist  <= s2;
      valid <= term;
      if (term) begin
        period <= cnt;
        ovf    <= sat;
      end
      if (state != IDLE && !en) begin
        state   <= IDLE;
        cnt     <= '0;
        per_cnt <= '0;
      end else if (state == IDLE) begin
        if (en) state <= ARM;
      end else if (state == ARM) begin
        if (rise) begin
          state   <= MEASURE;
          cnt     <= CNT_W'(1);
          per_cnt <= '0;
        end
      end else if (term) begin
        cnt     <= CNT_W'(1);
        per_cnt <= '0;
      end else begin
        cnt <= sat ? cnt : cnt + 1'b1;
        if (rise) per_cnt <= per_cnt + 1'b1;
      end
    end
  end
endmodule

// File: doc/fdiv_period_meter.md
FDIV_PERIOD_METER -- requirements
Module: fdiv_period_meter

Interface
REQ-001 Parameter: CNT_W, 16, width of period counter and result (8..32).
REQ-002 Parameter: N_PER, 4, number of input periods per measurement window (1..255).
REQ-003 Port: clk  input  1  measurement reference clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset.
REQ-005 Port: en  input  1  measurement enable, synchronous to clk.
REQ-006 Port: in  input  1  divided clock from the upstream divide-by-16 stage, asynchronous to clk.
REQ-007 Port: period  output  CNT_W  clk-cycle count spanning the last completed window.
REQ-008 Port: valid  output  1  one-cycle strobe marking a new period value.
REQ-009 Port: ovf  output  1  last reported period saturated.
REQ-010 Port: busy  output  1  high in ARM or MEASURE.
REQ-011 The block SHALL have one clock and a synchronous, active-high reset (rst).

Function
REQ-012 in SHALL pass through a 2-flop synchronizer, then one history flop; rise SHALL equal sync2 AND NOT hist.
REQ-013 Synchronizer and history flops SHALL run in every state; rise SHALL occur in the 3rd clk edge after in rises, given setup is met.
REQ-014 FSM states SHALL be IDLE, ARM, MEASURE; encoding is free.
REQ-015 IDLE: en=1 SHALL move to ARM next cycle; rise ignored.
REQ-016 ARM: rise SHALL move to MEASURE, load cnt=1, load per_cnt=0.
REQ-017 MEASURE, no rise: cnt SHALL increment by 1 per cycle, saturating at 2^CNT_W-1.
REQ-018 MEASURE, rise with per_cnt+1<N_PER: per_cnt SHALL increment; cnt SHALL increment normally.
REQ-019 MEASURE, rise with per_cnt+1=N_PER (terminal rise): period SHALL load cnt; valid SHALL pulse next cycle; cnt SHALL reload 1; per_cnt SHALL reload 0.
REQ-020 After a terminal rise, the block SHALL stay in MEASURE, and the terminal rise SHALL start the next window with no missed edge.
REQ-021 period SHALL equal the clk-cycle distance between the window's start rise and terminal rise; for a steady input of P clk cycles, period = N_PER*P.
REQ-022 ovf SHALL load 1 with period when cnt was saturated at the terminal rise, else 0; it SHALL change only on valid.
REQ-023 period and ovf SHALL hold between valid strobes.
REQ-024 en=0 in ARM or MEASURE SHALL force IDLE next cycle, clear cnt and per_cnt, suppress valid, and hold period and ovf.
REQ-025 en=0 on the same cycle as a terminal rise: the result SHALL still be reported (valid=1), then the FSM SHALL enter IDLE.
REQ-026 in stuck high or low SHALL produce no valid; cnt SHALL saturate, with no wrap-around.
REQ-027 busy SHALL be combinationally derived from state (ARM or MEASURE).

Reset
REQ-028 rst=1 SHALL force IDLE, cnt=0, per_cnt=0, sync/history flops=0, period=0, valid=0, ovf=0, busy=0 at the next clk edge, overriding en and rise.
REQ-029 Reset asserted mid-window SHALL discard the partial window; the first valid after release SHALL require a fresh ARM and a full window.
REQ-030 in high at reset release SHALL produce one rise after synchronization; this rise counts only if the FSM is in ARM.

Verification
REQ-031 N_PER=4, in period 16 clk, en=1 -> first valid about 5 input periods after en; then period=64, ovf=0, with valid every 64 cycles.
REQ-032 N_PER=1, in period 7 clk -> every valid reports period=7; successive valids are exactly 7 cycles apart.
REQ-033 CNT_W=8, N_PER=1, in period 300 clk -> period=255, ovf=1; then in period 100 -> period=100, ovf=0.
REQ-034 en dropped 20 cycles into a window -> no valid, busy=0 the next cycle, period unchanged; re-enable -> correct result after a full window.
REQ-035 rst pulsed mid-window -> next cycle period=0, valid=0, ovf=0, busy=0; with en=1 held, measurement restarts from ARM.
REQ-036 in held constant for 2^CNT_W+10 cycles in MEASURE -> no valid, no wrap; next two rises (N_PER=1) -> period=2^CNT_W-1, ovf=1.
